// File: rtl/spi_xfer_pkg.sv
// ============================================================================
// Module  : spi_xfer_pkg
// Brief   : Shared types, lane encodings and helpers for the SPI sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_xfer_pkg;

  localparam int TXSTR_W = 72;

  localparam logic [1:0] SPI_SINGLE = 2'd0;
  localparam logic [1:0] SPI_DUAL   = 2'd1;
  localparam logic [1:0] SPI_QUAD   = 2'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LEAD  = 3'd2,
    XFER  = 3'd3,
    TAIL  = 3'd4,
    HOLD  = 3'd5,
    DONE  = 3'd6
  } state_t;

  // log2 of the lane count; mode 3 falls back to single
  function automatic logic [1:0] lane_shift(input logic [1:0] mode);
    case (mode)
      SPI_DUAL: return 2'd1;
      SPI_QUAD: return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_sclk_gen.sv
// ============================================================================
// Module  : spi_sclk_gen
// Brief   : Half-period divider producing sclk level, edge pulses and a
//           rising-edge count while enabled.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_sclk_gen #(
  parameter int CLK_DIV_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [CLK_DIV_W-1:0] half,
  output logic                 sclk_lvl,
  output logic                 rise,
  output logic                 fall,
  output logic                 pre_tick,
  output logic [7:0]           edge_cnt
);

  localparam logic [CLK_DIV_W-1:0] ONE = CLK_DIV_W'(1);
  localparam logic [CLK_DIV_W-1:0] TWO = CLK_DIV_W'(2);

  logic [CLK_DIV_W-1:0] cnt;
  logic                 tick;

  // rise/fall flag the cycle whose closing edge toggles sclk
  assign tick     = en && (cnt == half - ONE);
  assign rise     = tick && !sclk_lvl;
  assign fall     = tick && sclk_lvl;
  assign pre_tick = en && (half != ONE) && (cnt == half - TWO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      sclk_lvl <= 1'b0;
      edge_cnt <= '0;
    end else if (!en) begin
      cnt      <= '0;
      sclk_lvl <= 1'b0;
      edge_cnt <= '0;
    end else if (tick) begin
      cnt      <= '0;
      sclk_lvl <= !sclk_lvl;
      if (!sclk_lvl) edge_cnt <= edge_cnt + 8'd1;
    end else begin
      cnt <= cnt + ONE;
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_xfer_ctrl.sv
// ============================================================================
// Module  : spi_xfer_ctrl
// Brief   : SPI transaction sequencer driving the latch stage. Optional
//           clock polarity support is built when SPI_XFER_CPOL_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_xfer_ctrl
  import spi_xfer_pkg::*;
#(
  parameter int CLK_DIV_W = 8,
  parameter int CS_HOLD   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [7:0]           cmd,
  input  logic [31:0]          addr,
  input  logic                 addr_en,
  input  logic [31:0]          wdata,
  input  logic [2:0]           wdata_bytes,
  input  logic [6:0]           rx_bits,
  input  logic [3:0]           dummy,
  input  logic [1:0]           tx_mode,
  input  logic [1:0]           rx_mode,
  input  logic [CLK_DIV_W-1:0] clk_div,
`ifdef SPI_XFER_CPOL_EN
  input  logic                 cpol,
`endif
  output logic                 sclk,
  output logic                 ss_n,
  output logic                 sclk_en,
  output logic                 latchout_en,
  output logic                 latchin_en,
  output logic                 setup_rst,
  output logic                 loadtxdata_en,
  output logic [TXSTR_W-1:0]   txstr,
  output logic [7:0]           mosistop_cnt,
  output logic [6:0]           misostop_cnt,
  output logic                 dualtx_en,
  output logic                 quadtx_en,
  output logic                 dualrx,
  output logic                 quadrx,
  output logic [3:0]           dummy_cycles,
  input  logic                 sending_done,
  output logic                 busy,
  output logic                 done
);

  localparam logic [CLK_DIV_W-1:0] ONE = CLK_DIV_W'(1);
  localparam int                   HOLD_W = (CS_HOLD < 2) ? 1 : $clog2(CS_HOLD);
  localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(CS_HOLD - 1);

  state_t               state;
  logic [CLK_DIV_W-1:0] half_r;
  logic [CLK_DIV_W-1:0] tail_cnt;
  logic [HOLD_W-1:0]    hold_cnt;
  logic [7:0]           edges_r;
  logic                 sticky_err;

  logic                 sclk_lvl, rise, fall, pre_tick;
  logic [7:0]           edge_cnt;

  logic [2:0]           wb;
  logic [1:0]           tx_sh, rx_sh;
  logic [7:0]           tx_l, tx_raw, tx_bits, edges;
  logic [6:0]           rx_l, rx_r, miso;
  logic [31:0]          wd;
  logic [CLK_DIV_W-1:0] half;

  // Request-derived strings and counts, registered on capture
  always_comb begin
    wb      = (wdata_bytes > 3'd4) ? 3'd4 : wdata_bytes;
    tx_sh   = lane_shift(tx_mode);
    rx_sh   = lane_shift(rx_mode);
    tx_l    = 8'd1 << tx_sh;
    rx_l    = 7'd1 << rx_sh;
    tx_raw  = 8'd8 + (addr_en ? 8'd32 : 8'd0) + {2'b00, wb, 3'b000};
    tx_bits = (tx_raw + tx_l - 8'd1) & ~(tx_l - 8'd1);
    rx_r    = (rx_bits + rx_l - 7'd1) & ~(rx_l - 7'd1);
    miso    = (rx_r >= rx_l) ? (rx_r - rx_l) : 7'd0;
    edges   = (tx_bits >> tx_sh) + {4'b0000, dummy} + {1'b0, rx_r >> rx_sh};
    case (wb)
      3'd0:    wd = 32'h0;
      3'd1:    wd = wdata & 32'hFF00_0000;
      3'd2:    wd = wdata & 32'hFFFF_0000;
      3'd3:    wd = wdata & 32'hFFFF_FF00;
      default: wd = wdata;
    endcase
    half = (clk_div == '0) ? ONE : clk_div;
  end

  spi_sclk_gen #(.CLK_DIV_W(CLK_DIV_W)) u_sclk_gen (
    .clk      (clk),
    .rst      (rst),
    .en       ((state == LEAD) || (state == XFER)),
    .half     (half_r),
    .sclk_lvl (sclk_lvl),
    .rise     (rise),
    .fall     (fall),
    .pre_tick (pre_tick),
    .edge_cnt (edge_cnt)
  );

`ifdef SPI_XFER_CPOL_EN
  logic cpol_r;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    cpol_r <= 1'b0;
    else if (req_valid && (state == IDLE))      cpol_r <= cpol;
  end
  // idle level tracks the live input so the pin settles before a request
  assign sclk = sclk_lvl ^ ((state == IDLE) ? cpol : cpol_r);
`else
  assign sclk = sclk_lvl;
`endif

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ss_n          <= 1'b1;
      sclk_en       <= 1'b0;
      latchout_en   <= 1'b0;
      latchin_en    <= 1'b0;
      setup_rst     <= 1'b0;
      loadtxdata_en <= 1'b0;
      done          <= 1'b0;
      txstr         <= '0;
      mosistop_cnt  <= '0;
      misostop_cnt  <= '0;
      dualtx_en     <= 1'b0;
      quadtx_en     <= 1'b0;
      dualrx        <= 1'b0;
      quadrx        <= 1'b0;
      dummy_cycles  <= '0;
      half_r        <= ONE;
      edges_r       <= '0;
      tail_cnt      <= '0;
      hold_cnt      <= '0;
      sticky_err    <= 1'b0;
    end else begin
      latchout_en   <= 1'b0;
      latchin_en    <= 1'b0;
      setup_rst     <= 1'b0;
      loadtxdata_en <= 1'b0;
      done          <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          txstr         <= {cmd, (addr_en ? addr : wd), (addr_en ? wd : 32'h0)};
          mosistop_cnt  <= tx_bits;
          misostop_cnt  <= miso;
          dualtx_en     <= (tx_mode == SPI_DUAL);
          quadtx_en     <= (tx_mode == SPI_QUAD);
          dualrx        <= (rx_mode == SPI_DUAL);
          quadrx        <= (rx_mode == SPI_QUAD);
          dummy_cycles  <= dummy;
          half_r        <= half;
          edges_r       <= edges;
          setup_rst     <= 1'b1;
          loadtxdata_en <= 1'b1;
          ss_n          <= 1'b0;
          state         <= SETUP;
        end
        SETUP: begin
          // with a one-cycle half-period the whole LEAD is the pre-rise cycle
          latchout_en <= (half_r == ONE);
          state       <= LEAD;
        end
        LEAD: begin
          if (pre_tick) latchout_en <= 1'b1;
          if (rise) begin
            latchin_en <= 1'b1;
            sclk_en    <= 1'b1;
            state      <= XFER;
          end
        end
        XFER: begin
          if (rise) latchin_en <= 1'b1;
          if (fall) begin
            if (edge_cnt == edges_r) begin
              sclk_en  <= 1'b0;
              tail_cnt <= '0;
              state    <= TAIL;
              if (!sending_done) sticky_err <= 1'b1;
            end else begin
              latchout_en <= 1'b1;
            end
          end
        end
        TAIL: begin
          if (tail_cnt == half_r - ONE) begin
            ss_n     <= 1'b1;
            hold_cnt <= '0;
            if (CS_HOLD == 0) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= HOLD;
            end
          end else begin
            tail_cnt <= tail_cnt + ONE;
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_xfer_ctrl.sv
// ============================================================================
// Module  : tb_spi_xfer_ctrl
// Brief   : Directed self-checking bench for spi_xfer_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_xfer_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [7:0]  cmd;
  logic [31:0] addr;
  logic        addr_en;
  logic [31:0] wdata;
  logic [2:0]  wdata_bytes;
  logic [6:0]  rx_bits;
  logic [3:0]  dummy;
  logic [1:0]  tx_mode, rx_mode;
  logic [7:0]  clk_div;
  logic        cpol;
  logic        sclk, ss_n, sclk_en, latchout_en, latchin_en, setup_rst, loadtxdata_en;
  logic [71:0] txstr;
  logic [7:0]  mosistop_cnt;
  logic [6:0]  misostop_cnt;
  logic        dualtx_en, quadtx_en, dualrx, quadrx;
  logic [3:0]  dummy_cycles;
  logic        sending_done;
  logic        busy, done;

  int tests = 0;
  int fails = 0;

  int m_rise, m_li, m_sslow, m_setup, m_rrbusy, m_t1, m_t2;
  bit m_done, m_timeout;

  always #5 clk = ~clk;

  spi_xfer_ctrl #(.CLK_DIV_W(8), .CS_HOLD(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .cmd(cmd), .addr(addr), .addr_en(addr_en), .wdata(wdata),
    .wdata_bytes(wdata_bytes), .rx_bits(rx_bits), .dummy(dummy),
    .tx_mode(tx_mode), .rx_mode(rx_mode), .clk_div(clk_div),
`ifdef SPI_XFER_CPOL_EN
    .cpol(cpol),
`endif
    .sclk(sclk), .ss_n(ss_n), .sclk_en(sclk_en), .latchout_en(latchout_en),
    .latchin_en(latchin_en), .setup_rst(setup_rst), .loadtxdata_en(loadtxdata_en),
    .txstr(txstr), .mosistop_cnt(mosistop_cnt), .misostop_cnt(misostop_cnt),
    .dualtx_en(dualtx_en), .quadtx_en(quadtx_en), .dualrx(dualrx), .quadrx(quadrx),
    .dummy_cycles(dummy_cycles), .sending_done(sending_done), .busy(busy), .done(done)
  );

  task automatic drive_req(input logic [7:0] c, input logic [31:0] a, input logic ae,
                           input logic [31:0] wd, input logic [2:0] wb, input logic [6:0] rb,
                           input logic [3:0] dm, input logic [1:0] tm, input logic [1:0] rm,
                           input logic [7:0] cd);
    @(negedge clk);
    cmd = c; addr = a; addr_en = ae; wdata = wd; wdata_bytes = wb;
    rx_bits = rb; dummy = dm; tx_mode = tm; rx_mode = rm; clk_div = cd;
    req_valid = 1'b1;
  endtask

  // Samples every negedge until done (or a given rising-edge count)
  task automatic measure(input int stop_rise, input bit drop_valid);
    logic prev;
    m_rise = 0; m_li = 0; m_sslow = 0; m_setup = 0; m_rrbusy = 0;
    m_t1 = 0; m_t2 = 0; m_done = 0; m_timeout = 0;
    prev = sclk;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (drop_valid) req_valid = 1'b0;
      if (!ss_n) m_sslow++;
      if (setup_rst) m_setup++;
      if (latchin_en) m_li++;
      if (req_ready && busy) m_rrbusy++;
      if (sclk && !prev) begin
        m_rise++;
        if (m_rise == 1) m_t1 = cyc;
        if (m_rise == 2) m_t2 = cyc;
      end
      prev = sclk;
      if (stop_rise != 0 && m_rise == stop_rise) return;
      if (done) begin
        m_done = 1'b1;
        return;
      end
    end
    m_timeout = 1'b1;
  endtask

  task automatic test_reset;
    tests++; if (ss_n !== 1'b1) begin fails++; $display("FAIL rst_ss_n got %b want 1", ss_n); end
    tests++; if (sclk !== 1'b0) begin fails++; $display("FAIL rst_sclk got %b want 0", sclk); end
    tests++; if ({busy, done, setup_rst, latchin_en, latchout_en} !== 5'b0) begin
      fails++; $display("FAIL rst_flags got %b want 00000", {busy, done, setup_rst, latchin_en, latchout_en}); end
    tests++; if ({txstr, mosistop_cnt, misostop_cnt} !== 87'h0) begin
      fails++; $display("FAIL rst_regs got %h want 0", {txstr, mosistop_cnt, misostop_cnt}); end
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_ready got %b want 1", req_ready); end
  endtask

  task automatic test_single_read;
    drive_req(8'h9F, 32'h0, 1'b0, 32'h0, 3'd0, 7'd24, 4'd0, 2'd0, 2'd0, 8'd2);
    measure(0, 1'b1);
    tests++; if (m_done !== 1'b1) begin fails++; $display("FAIL t1_done got %b want 1", m_done); end
    tests++; if (txstr[71:64] !== 8'h9F) begin fails++; $display("FAIL t1_cmd got %h want 9f", txstr[71:64]); end
    tests++; if (mosistop_cnt !== 8'd8) begin fails++; $display("FAIL t1_mosi got %0d want 8", mosistop_cnt); end
    tests++; if (misostop_cnt !== 7'd23) begin fails++; $display("FAIL t1_miso got %0d want 23", misostop_cnt); end
    tests++; if (m_rise !== 32) begin fails++; $display("FAIL t1_rises got %0d want 32", m_rise); end
    tests++; if (m_li !== 32) begin fails++; $display("FAIL t1_latchin got %0d want 32", m_li); end
    tests++; if (m_t2 - m_t1 !== 4) begin fails++; $display("FAIL t1_period got %0d want 4", m_t2 - m_t1); end
    tests++; if (m_sslow !== 131) begin fails++; $display("FAIL t1_sslow got %0d want 131", m_sslow); end
    @(negedge clk);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL t1_done_once got %b want 0", done); end
  endtask

  task automatic test_quad_read;
    drive_req(8'hEB, 32'h0012_3456, 1'b1, 32'h0, 3'd0, 7'd32, 4'd4, 2'd2, 2'd2, 8'd1);
    measure(0, 1'b1);
    tests++; if (m_done !== 1'b1) begin fails++; $display("FAIL t2_done got %b want 1", m_done); end
    tests++; if (txstr !== 72'hEB_0012_3456_0000_0000) begin fails++; $display("FAIL t2_txstr got %h want eb0012345600000000", txstr); end
    tests++; if (mosistop_cnt !== 8'd40) begin fails++; $display("FAIL t2_mosi got %0d want 40", mosistop_cnt); end
    tests++; if (misostop_cnt !== 7'd28) begin fails++; $display("FAIL t2_miso got %0d want 28", misostop_cnt); end
    tests++; if ({quadtx_en, quadrx, dualtx_en, dualrx} !== 4'b1100) begin
      fails++; $display("FAIL t2_lanes got %b want 1100", {quadtx_en, quadrx, dualtx_en, dualrx}); end
    tests++; if (dummy_cycles !== 4'd4) begin fails++; $display("FAIL t2_dummy got %0d want 4", dummy_cycles); end
    tests++; if (m_li !== 22) begin fails++; $display("FAIL t2_latchin got %0d want 22", m_li); end
    tests++; if (m_sslow !== 46) begin fails++; $display("FAIL t2_sslow got %0d want 46", m_sslow); end
  endtask

  task automatic test_dual_write;
    drive_req(8'h02, 32'h1234_5678, 1'b1, 32'hA5A5_A5A5, 3'd4, 7'd0, 4'd0, 2'd1, 2'd1, 8'd3);
    measure(0, 1'b1);
    tests++; if (m_done !== 1'b1) begin fails++; $display("FAIL t3_done got %b want 1", m_done); end
    tests++; if (txstr !== 72'h02_1234_5678_A5A5_A5A5) begin fails++; $display("FAIL t3_txstr got %h want 0212345678a5a5a5a5", txstr); end
    tests++; if (mosistop_cnt !== 8'd72) begin fails++; $display("FAIL t3_mosi got %0d want 72", mosistop_cnt); end
    tests++; if (misostop_cnt !== 7'd0) begin fails++; $display("FAIL t3_miso got %0d want 0", misostop_cnt); end
    tests++; if (m_rise !== 36) begin fails++; $display("FAIL t3_rises got %0d want 36", m_rise); end
    tests++; if (m_sslow !== 220) begin fails++; $display("FAIL t3_sslow got %0d want 220", m_sslow); end
  endtask

  task automatic test_back_to_back;
    drive_req(8'h05, 32'h0, 1'b0, 32'h1122_3344, 3'd5, 7'd8, 4'd0, 2'd0, 2'd0, 8'd1);
    measure(0, 1'b0);
    tests++; if (m_done !== 1'b1) begin fails++; $display("FAIL t4_done got %b want 1", m_done); end
    tests++; if (m_setup !== 1) begin fails++; $display("FAIL t4_starts got %0d want 1", m_setup); end
    tests++; if (m_rrbusy !== 0) begin fails++; $display("FAIL t4_ready_busy got %0d want 0", m_rrbusy); end
    tests++; if (txstr !== 72'h05_1122_3344_0000_0000) begin fails++; $display("FAIL t4_txstr got %h want 051122334400000000", txstr); end
    tests++; if (mosistop_cnt !== 8'd40) begin fails++; $display("FAIL t4_mosi got %0d want 40", mosistop_cnt); end
    tests++; if (m_sslow !== 98) begin fails++; $display("FAIL t4_sslow got %0d want 98", m_sslow); end
    @(negedge clk);
    tests++; if ({req_ready, busy} !== 2'b10) begin fails++; $display("FAIL t4_idle got %b want 10", {req_ready, busy}); end
    @(negedge clk);
    tests++; if (setup_rst !== 1'b1) begin fails++; $display("FAIL t4_second_accept got %b want 1", setup_rst); end
    req_valid = 1'b0;
    measure(0, 1'b0);
    tests++; if (m_done !== 1'b1) begin fails++; $display("FAIL t4_second_done got %b want 1", m_done); end
  endtask

  task automatic test_rst_mid;
    drive_req(8'h9F, 32'h0, 1'b0, 32'h0, 3'd0, 7'd24, 4'd0, 2'd0, 2'd0, 8'd2);
    measure(5, 1'b1);
    tests++; if (m_rise !== 5) begin fails++; $display("FAIL t5_reach got %0d want 5", m_rise); end
    rst = 1'b1;
    #1;
    tests++; if ({ss_n, sclk, busy} !== 3'b100) begin fails++; $display("FAIL t5_async got %b want 100", {ss_n, sclk, busy}); end
    @(negedge clk);
    rst = 1'b0;
    drive_req(8'h9F, 32'h0, 1'b0, 32'h0, 3'd0, 7'd24, 4'd0, 2'd0, 2'd0, 8'd2);
    measure(0, 1'b1);
    tests++; if (m_done !== 1'b1 || m_li !== 32) begin
      fails++; $display("FAIL t5_recover got done=%b edges=%0d want done=1 edges=32", m_done, m_li); end
  endtask

  task automatic test_clk_div0;
`ifdef SPI_XFER_CPOL_EN
    cpol = 1'b1;
    @(negedge clk);
    tests++; if (sclk !== 1'b1) begin fails++; $display("FAIL t6_idle_pre got %b want 1", sclk); end
`endif
    drive_req(8'h06, 32'h0, 1'b0, 32'hDEAD_BEEF, 3'd2, 7'd5, 4'd0, 2'd3, 2'd1, 8'd0);
    measure(0, 1'b1);
    tests++; if (m_done !== 1'b1) begin fails++; $display("FAIL t6_done got %b want 1", m_done); end
    tests++; if (txstr !== 72'h06_DEAD_0000_0000_0000) begin fails++; $display("FAIL t6_txstr got %h want 06dead000000000000", txstr); end
    tests++; if ({mosistop_cnt, misostop_cnt} !== {8'd24, 7'd4}) begin
      fails++; $display("FAIL t6_counts got %0d/%0d want 24/4", mosistop_cnt, misostop_cnt); end
    tests++; if ({dualtx_en, quadtx_en, dualrx} !== 3'b001) begin
      fails++; $display("FAIL t6_lanes got %b want 001", {dualtx_en, quadtx_en, dualrx}); end
    tests++; if (m_t2 - m_t1 !== 2) begin fails++; $display("FAIL t6_period got %0d want 2", m_t2 - m_t1); end
    tests++; if (m_li !== 27) begin fails++; $display("FAIL t6_latchin got %0d want 27", m_li); end
    tests++; if (m_sslow !== 56) begin fails++; $display("FAIL t6_sslow got %0d want 56", m_sslow); end
`ifdef SPI_XFER_CPOL_EN
    @(negedge clk);
    tests++; if (sclk !== 1'b1) begin fails++; $display("FAIL t6_idle_post got %b want 1", sclk); end
    cpol = 1'b0;
`endif
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; cmd = '0; addr = '0; addr_en = 1'b0; wdata = '0;
    wdata_bytes = '0; rx_bits = '0; dummy = '0; tx_mode = '0; rx_mode = '0;
    clk_div = 8'd1; cpol = 1'b0; sending_done = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_single_read();
    test_quad_read();
    test_dual_write();
    test_back_to_back();
    test_rst_mid();
    test_clk_div0();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
